// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
// Sits behind a UART receiver. It finds frames of the form
// [SOF][LEN][LEN payload bytes][CSUM] in the received byte stream and checks
// the length and the checksum. The payload is held in a local buffer and is
// only forwarded after the checksum passes. The output is a valid/ready byte
// stream with a last-byte flag.
// A frame is good when LEN + sum(payload) + CSUM == 0 (mod 256).
// MAX_LEN must be at least 2 and no more than 255.

module uart_rx_frame_parser #(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SOF         = 8'h7E,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx_valid,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_break,
  output logic       frm_valid,
  input  logic       frm_ready,
  output logic [7:0] frm_data,
  output logic       frm_last,
  output logic [7:0] frm_len,
  output logic       err_csum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       busy
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]       MAX_LEN_B    = 8'(MAX_LEN);
  // The counter value after TIMEOUT_CYC idle cycles.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DELIVER
  } state_t;

  state_t           state_q, state_n;
  logic [7:0]       len_q, len_n;
  logic [7:0]       sum_q, sum_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic err_csum_q, err_csum_n;
  logic err_len_q, err_len_n;
  logic err_timeout_q, err_timeout_n;
  logic err_overrun_q, err_overrun_n;

  logic             wr_en;
  logic [7:0]       payload_mem [MAX_LEN];

  // Helpers shared by the state logic and the outputs.
  logic [7:0] idx_ext;
  logic [7:0] sum_plus;
  logic       at_last_idx;

  assign idx_ext     = 8'(idx_q);
  assign sum_plus    = sum_q + uart_rx_data;
  assign at_last_idx = (idx_ext == len_q - 8'd1);

  // Next-state logic. It also handles the index, checksum and timeout bookkeeping,
  // the buffer write enable, and the error pulses.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
    state_n       = state_q;
    len_n         = len_q;
    sum_n         = sum_q;
    idx_n         = idx_q;
    cnt_n         = cnt_q;
    wr_en         = 1'b0;
    err_csum_n    = 1'b0;
    err_len_n     = 1'b0;
    err_timeout_n = 1'b0;
    err_overrun_n = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        cnt_n = '0;
        if (uart_rx_valid && uart_rx_data == SOF) begin
          state_n = ST_LEN;
        end
      end

      ST_LEN, ST_PAYLOAD, ST_CSUM: begin
        if (uart_rx_break) begin
          // A break throws the frame away quietly. Any byte in the same cycle is dropped too.
          state_n = ST_HUNT;
          cnt_n   = '0;
        end else if (uart_rx_valid) begin
          cnt_n = '0;
          unique case (state_q)
            ST_LEN: begin
              if (uart_rx_data != 8'd0 && uart_rx_data <= MAX_LEN_B) begin
                len_n   = uart_rx_data;
                sum_n   = uart_rx_data;
                idx_n   = '0;
                state_n = ST_PAYLOAD;
              end else begin
                err_len_n = 1'b1;
                state_n   = ST_HUNT;
              end
            end
            ST_PAYLOAD: begin
              // An SOF byte here is plain data. There is no byte stuffing.
              wr_en = 1'b1;
              sum_n = sum_plus;
              if (at_last_idx) begin
                state_n = ST_CSUM;
              end else begin
                idx_n = idx_q + IDX_W'(1);
              end
            end
            default: begin
              if (sum_plus == 8'd0) begin
                idx_n   = '0;
                state_n = ST_DELIVER;
              end else begin
                err_csum_n = 1'b1;
                state_n    = ST_HUNT;
              end
            end
          endcase
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_timeout_n = 1'b1;
          cnt_n         = '0;
          state_n       = ST_HUNT;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_DELIVER: begin
        // The receiver cannot be stalled. A byte that arrives now is lost, and the delivery carries on.
        err_overrun_n = uart_rx_valid;
        if (frm_ready) begin
          if (at_last_idx) begin
            idx_n   = '0;
            state_n = ST_HUNT;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end

      default: state_n = ST_HUNT;
    endcase
  end

  // State, counter and error-pulse registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register updates from pre-edge values.
    if (reset) begin
      state_q       <= ST_HUNT;
      len_q         <= '0;
      sum_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      err_csum_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_n;
      len_q         <= len_n;
      sum_q         <= sum_n;
      idx_q         <= idx_n;
      cnt_q         <= cnt_n;
      err_csum_q    <= err_csum_n;
      err_len_q     <= err_len_n;
      err_timeout_q <= err_timeout_n;
      err_overrun_q <= err_overrun_n;
    end
  end

  // Payload buffer. Each entry is written before it is read within a frame.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset. Stale data is never visible, because delivery only reads indices written by the current frame.
    if (wr_en && !reset) begin
      payload_mem[idx_q] <= uart_rx_data;
    end
  end

  // Output stream. The data, last flag and length are gated so that they read 0 when no delivery is in progress.
  always_comb begin
    frm_valid = (state_q == ST_DELIVER);
    frm_data  = frm_valid ? payload_mem[idx_q] : 8'h00;
    frm_last  = frm_valid && at_last_idx;
    frm_len   = frm_valid ? len_q : 8'h00;
    busy      = (state_q != ST_HUNT);
  end

  assign err_csum    = err_csum_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Testbench for uart_rx_frame_parser.
// It runs directed frames and then randomised frames. The expected payload and
// error counts for each frame come from the frame rules: LEN must be in range,
// and LEN + payload + CSUM must be 0 mod 256. A monitor checks the handshake,
// the stability of held outputs, and the error pulses.

module tb_uart_rx_frame_parser;

  localparam int         TMO   = 300;
  localparam int         MAXL  = 16;
  localparam logic [7:0] SOF_B = 8'h7E;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_break;
  logic       frm_valid;
  logic       frm_ready;
  logic [7:0] frm_data;
  logic       frm_last;
  logic [7:0] frm_len;
  logic       err_csum, err_len, err_timeout, err_overrun;
  logic       busy;

  uart_rx_frame_parser #(
    .MAX_LEN    (MAXL),
    .SOF        (SOF_B),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data (uart_rx_data),
    .uart_rx_break(uart_rx_break),
    .frm_valid    (frm_valid),
    .frm_ready    (frm_ready),
    .frm_data     (frm_data),
    .frm_last     (frm_last),
    .frm_len      (frm_len),
    .err_csum     (err_csum),
    .err_len      (err_len),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // The monitor records the accepted bytes and counts the error pulses.
  logic [7:0] got_q[$];
  bit         got_last_q[$];
  int         n_csum = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
  logic [7:0] exp_len = 8'd0;
  int         ready_mode = 0;   // 0 = always ready, 1 = random, 2 = held low

  logic       hold = 1'b0, prev_valid = 1'b0, h_last = 1'b0;
  logic [7:0] h_data = 8'd0, h_len = 8'd0;

  // The consumer changes its ready just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       frm_ready = 1'b1;
      1:       frm_ready = 1'($urandom_range(0, 1));
      default: frm_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      hold       = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", frm_valid, 1'b1);
        check("hold_data", frm_data, h_data);
        check("hold_last", frm_last, h_last);
        check("hold_len", frm_len, h_len);
      end
      if (err_csum || err_len || err_timeout || err_overrun) begin
        check("err_onehot", $countones({err_csum, err_len, err_timeout, err_overrun}), 1);
        check("err_at_rise", frm_valid && !prev_valid, 1'b0);
      end
      n_csum += int'(err_csum);
      n_len  += int'(err_len);
      n_tmo  += int'(err_timeout);
      n_ovr  += int'(err_overrun);
      if (frm_valid && frm_ready) begin
        got_q.push_back(frm_data);
        got_last_q.push_back(frm_last);
        check("frm_len", frm_len, exp_len);
      end
      hold       = frm_valid && !frm_ready;
      h_data     = frm_data;
      h_last     = frm_last;
      h_len      = frm_len;
      prev_valid = frm_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  logic [7:0] tx_q[$];

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1 uart_rx_valid = 1'b1;
    uart_rx_data = b;
    @(posedge clk);
    #1 uart_rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_wait", busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Builds a frame in tx_q: leading non-SOF garbage, then SOF, LEN, the payload and CSUM.
  task automatic make_frame(input int ngarb, input int len, input bit corrupt);
    logic [7:0] b;
    int         s;
    tx_q.delete();
    for (int i = 0; i < ngarb; i++) begin
      do b = 8'($urandom); while (b == SOF_B);
      tx_q.push_back(b);
    end
    tx_q.push_back(SOF_B);
    tx_q.push_back(8'(len));
    s = len;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      s += b;
      tx_q.push_back(b);
    end
    b = 8'((256 - (s % 256)) % 256);
    if (corrupt) b = b ^ 8'($urandom_range(1, 255));
    tx_q.push_back(b);
  endtask

  // Sends tx_q and works out the expected result from the frame rules. It then checks latency, payload, flags and error pulses.
  task automatic run_frame(input string tag);
    int         s, len, total;
    bit         len_ok, good;
    int         c0, l0, t0, o0;
    logic [7:0] pl[$];
    s = 0;
    while (s < tx_q.size() && tx_q[s] != SOF_B) s++;
    len    = int'(tx_q[s+1]);
    len_ok = (len >= 1) && (len <= MAXL);
    good   = 1'b0;
    if (len_ok) begin
      total = len;
      for (int i = 0; i < len; i++) begin
        pl.push_back(tx_q[s+2+i]);
        total += int'(tx_q[s+2+i]);
      end
      total += int'(tx_q[s+2+len]);
      good = (total % 256) == 0;
    end
    exp_len = 8'(len);
    got_q.delete();
    got_last_q.delete();
    c0 = n_csum; l0 = n_len; t0 = n_tmo; o0 = n_ovr;
    for (int i = 0; i < tx_q.size(); i++)
      send_byte(tx_q[i], (i == tx_q.size() - 1) ? 0 : int'($urandom_range(0, 3)));
    @(negedge clk);
    check({tag, "_latency"}, frm_valid, good);
    wait_idle(2000);
    check({tag, "_count"}, got_q.size(), good ? len : 0);
    if (good) begin
      for (int i = 0; i < len && i < got_q.size(); i++) begin
        check({tag, "_data"}, got_q[i], pl[i]);
        check({tag, "_last"}, got_last_q[i], i == len - 1);
      end
    end
    check({tag, "_err_csum"}, n_csum - c0, (len_ok && !good) ? 1 : 0);
    check({tag, "_err_len"}, n_len - l0, len_ok ? 0 : 1);
    check({tag, "_err_tmo"}, n_tmo - t0, 0);
    check({tag, "_err_ovr"}, n_ovr - o0, 0);
  endtask

  task automatic good_frame_1;
    tx_q = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
  endtask

  initial begin
    int         t0, c0, l0, o0;
    int         kind;
    int         len;
    reset         = 1'b1;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_break = 1'b0;
    frm_ready     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {frm_valid, frm_data, frm_last, frm_len,
                          err_csum, err_len, err_timeout, err_overrun, busy}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed 1: a good frame with the consumer always ready.
    good_frame_1();
    run_frame("t1_good");

    // Directed 2: the same frame with a bad checksum.
    tx_q = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    run_frame("t2_badcsum");

    // Directed 3: LEN = 0, then LEN = MAX_LEN + 1, then a good frame.
    tx_q = '{8'h7E, 8'h00};
    run_frame("t3_len0");
    tx_q = '{8'h7E, 8'h11};
    run_frame("t3_len17");
    good_frame_1();
    run_frame("t3_good");

    // Directed 4: an inter-byte timeout inside a frame.
    t0 = n_tmo; c0 = n_csum; l0 = n_len;
    send_byte(8'h7E, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, TMO / 2);
    check("t4_no_early_tmo", n_tmo - t0, 0);
    check("t4_busy_mid", busy, 1'b1);
    repeat (TMO) @(negedge clk);
    check("t4_tmo_pulse", n_tmo - t0, 1);
    check("t4_busy", busy, 1'b0);
    check("t4_no_other", (n_csum - c0) + (n_len - l0), 0);
    good_frame_1();
    run_frame("t4_good");

    // Break in the middle of a frame: return to hunting with no error pulse.
    t0 = n_tmo; c0 = n_csum; l0 = n_len; o0 = n_ovr;
    send_byte(8'h7E, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    @(posedge clk);
    #1 uart_rx_break = 1'b1;
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h22;
    @(posedge clk);
    #1 uart_rx_break = 1'b0;
    uart_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("brk_busy", busy, 1'b0);
    check("brk_no_err", (n_tmo - t0) + (n_csum - c0) + (n_len - l0) + (n_ovr - o0), 0);
    good_frame_1();
    run_frame("brk_good");

    // Directed 5: backpressure for 100 cycles, plus an overrun byte.
    ready_mode = 2;
    exp_len    = 8'd3;
    got_q.delete();
    got_last_q.delete();
    o0 = n_ovr;
    good_frame_1();
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 0);
    @(negedge clk);
    check("t5_valid", frm_valid, 1'b1);
    repeat (100) @(negedge clk);
    check("t5_held_data", frm_data, 8'h11);
    send_byte(8'h55, 0);
    repeat (2) @(negedge clk);
    check("t5_overrun", n_ovr - o0, 1);
    ready_mode = 0;
    wait_idle(200);
    check("t5_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t5_b0", got_q[0], 8'h11);
      check("t5_b1", got_q[1], 8'h22);
      check("t5_b2", got_q[2], 8'h33);
      check("t5_last", {got_last_q[0], got_last_q[1], got_last_q[2]}, 3'b001);
    end

    // Directed 6: garbage before SOF, then a reset in the middle of the payload.
    tx_q = '{8'h00, 8'hFF, 8'h12, 8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    run_frame("t6_garbage");
    send_byte(8'h7E, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_outputs", {frm_valid, frm_data, frm_last, frm_len,
                             err_csum, err_len, err_timeout, err_overrun, busy}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    good_frame_1();
    run_frame("t6_good");

    // Random frames with a random consumer.
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 3) begin
        tx_q.delete();
        tx_q.push_back(SOF_B);
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAXL + 1, 255));
        tx_q.push_back(8'(len));
      end else begin
        make_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, MAXL)), kind == 2);
      end
      run_frame("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
